uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, maximum data bits per frame (legal 5..9).
REQ-002 SHALL have parameter PRESCALE_W, default 6, width of the Prescale input.
REQ-003 SHALL have port CLK  input  1  single receive clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  synchronous active-low reset.
REQ-005 SHALL have port RX_IN  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port PAR_EN  input  1  parity bit present when 1.
REQ-007 SHALL have port PAR_TYP  input  1  0 even parity, 1 odd parity.
REQ-008 SHALL have port STP2  input  1  two stop bits when 1, one stop bit when 0.
REQ-009 SHALL have port Prescale  input  PRESCALE_W  CLK cycles per bit.
REQ-010 SHALL have port P_DATA  output  DATA_WIDTH  received word, LSB received first.
REQ-011 SHALL have port data_valid  output  1  one-cycle pulse, P_DATA holds a good frame.
REQ-012 SHALL have port par_err  output  1  one-cycle pulse, parity mismatch.
REQ-013 SHALL have port stp_err  output  1  one-cycle pulse, a stop bit was sampled low.
REQ-014 SHALL have port brk_det  output  1  one-cycle pulse, break detected (tied 0 when the break feature is compiled out).

Function
REQ-015 SHALL pass RX_IN through a 2-flop synchroniser; all decisions SHALL use the synchronised value.
REQ-016 SHALL latch PAR_EN, PAR_TYP, STP2 and Prescale in the cycle the start edge is detected; mid-frame input changes SHALL NOT affect the frame in progress.
REQ-017 SHALL treat a latched Prescale below 8 as 8 and SHALL ignore its LSB (even only).
REQ-018 SHALL use an edge counter running 0..P-1 per bit and a bit counter; P is the latched Prescale.
REQ-019 SHALL sample at edge counts P/2-1, P/2 and P/2+1; the bit value is the 2-of-3 majority, decided at P/2+1.
REQ-020 SHALL implement states IDLE, START, DATA, PARITY, STOP1, STOP2 and BREAK_WAIT.
REQ-021 IDLE->START on synchronised RX_IN = 0; edge counter cleared that cycle.
REQ-022 START: a majority of 1 SHALL be a glitch -> IDLE with no output pulses; otherwise -> DATA at count P-1.
REQ-023 DATA SHALL shift in DATA_WIDTH bits LSB-first, then go to PARITY if PAR_EN, else STOP1.
REQ-024 PARITY: the parity error is computed over DATA_WIDTH data bits plus the parity bit, per the latched PAR_TYP.
REQ-025 The final stop bit (STOP1 if !STP2, else STOP2) SHALL end the frame at its decision point (P/2+1) and return to IDLE the next cycle, so the next start edge is seen during the remaining half stop bit.
REQ-026 In the cycle after the final decision, exactly one of these SHALL occur: data_valid=1 with P_DATA updated if no error; otherwise par_err and/or stp_err=1 with P_DATA unchanged.
REQ-027 A first stop bit sampled low with STP2=1 SHALL flag stp_err at frame end; the second stop bit is still sampled.
REQ-028 P_DATA SHALL change only in the cycle data_valid asserts.
REQ-029 Back-to-back frames with zero idle bits SHALL be received without loss.

Reset
REQ-030 RST=0 at a rising edge SHALL force IDLE, clear all counters, and set P_DATA=0, data_valid=0, par_err=0, stp_err=0, brk_det=0, synchroniser=1.
REQ-031 Reset mid-frame SHALL discard the frame with no output pulse; reception SHALL restart on the first start edge after RST=1.

Configuration
REQ-032 Macro UART_RX_BREAK_DET_EN SHALL compile break detection in.
REQ-033 With UART_RX_BREAK_DET_EN: all data bits 0, parity bit 0 (if enabled) and first stop bit 0 SHALL pulse brk_det only (no stp_err, par_err or data_valid), then go to BREAK_WAIT until synchronised RX_IN = 1, then IDLE.
REQ-034 Without UART_RX_BREAK_DET_EN: brk_det SHALL be constant 0, such a frame SHALL report stp_err, and BREAK_WAIT logic SHALL be absent.

Structure
REQ-035 Package uart_rx_pkg SHALL hold the state enum, the minimum prescale constant (8) and the DATA_WIDTH legal-range constants.
REQ-036 A sub-module uart_rx_sampler SHALL hold the synchroniser, the 3-point capture and the majority vote.

Verification
REQ-037 8N1, Prescale=8, byte 0xA5 -> data_valid pulse, P_DATA=0xA5, no error flags.
REQ-038 PAR_EN=1, PAR_TYP=0, byte 0x0F, parity bit driven 1 -> par_err pulse, no data_valid, P_DATA unchanged.
REQ-039 Start low for 3 cycles only at Prescale=16 -> no output pulses, FSM back in IDLE; following byte 0x3C received correctly.
REQ-040 STP2=1, Prescale=32, second stop bit low -> stp_err pulse; then two frames 0x55 and 0xAA with zero idle -> two data_valid pulses.
REQ-041 Prescale changed from 8 to 16 mid-frame -> current frame decoded at 8; next frame decoded at 16.
REQ-042 With the macro, RX_IN held low for 12 bit times then high -> single brk_det pulse, then IDLE; without the macro -> stp_err pulse.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the configurable UART receiver.
// Optional break detection is compiled in with `define UART_RX_BREAK_DET_EN.
package uart_rx_pkg;

  // Smallest usable prescale; lower (or odd) requests are rounded up/down to this grid.
  localparam int MIN_PRESCALE = 8;

  // Legal range for the number of data bits per frame.
  localparam int DATA_WIDTH_MIN = 5;
  localparam int DATA_WIDTH_MAX = 9;

  // Receiver frame states. BREAK_WAIT is only reachable when break detection is built in.
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_START      = 3'd1,
    S_DATA       = 3'd2,
    S_PARITY     = 3'd3,
    S_STOP1      = 3'd4,
    S_STOP2      = 3'd5,
    S_BREAK_WAIT = 3'd6
  } rx_state_t;

  // 2-of-3 majority vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser plus three-point mid-bit capture and majority vote.
// Samples are taken at edge counts half-1 and half; the third is the live
// synchronised value at half+1, so o_bit is valid in the decision cycle.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rx,
  input  logic [PRESCALE_W-1:0] i_edge_cnt,
  input  logic [PRESCALE_W-1:0] i_half,
  output logic                  o_rx_sync,
  output logic                  o_bit
);

  logic r_sync1;
  logic r_sync2;
  logic r_s0;
  logic r_s1;

  // Two-flop synchroniser (idle high) and capture of the first two vote samples.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_s0    <= 1'b1;
      r_s1    <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      if (i_edge_cnt == i_half - PRESCALE_W'(1)) r_s0 <= r_sync2;
      if (i_edge_cnt == i_half)                  r_s1 <= r_sync2;
    end
  end

  assign o_rx_sync = r_sync2;
  assign o_bit     = maj3(r_s0, r_s1, r_sync2);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional parity, 1 or 2 stop bits,
// runtime prescale. Frame settings are captured at the start edge.
// Break detection is compiled in with `define UART_RX_BREAK_DET_EN.
module uart_rx_cfg
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STP2,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  brk_det
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  rx_state_t             r_state;
  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [BCW-1:0]        r_bit_cnt;
  logic [PRESCALE_W-1:0] r_prescale;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_stp2;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_bit;
  logic                  r_stp1_err;
  logic [DATA_WIDTH-1:0] r_p_data;
  logic                  r_data_valid;
  logic                  r_par_err;
  logic                  r_stp_err;

  logic [PRESCALE_W-1:0] w_presc_even;
  logic [PRESCALE_W-1:0] w_presc_eff;
  logic [PRESCALE_W-1:0] w_half;
  logic                  w_rx_sync;
  logic                  w_bit;
  logic                  w_decide;
  logic                  w_bit_end;
  logic                  w_par_mismatch;
  logic                  w_final;
  logic                  w_final_ok;
  logic                  w_final_stp_err;
  logic                  w_final_par_err;

  // Prescale is forced even and clamped to the minimum before being latched.
  assign w_presc_even = Prescale & ~PRESCALE_W'(1);
  assign w_presc_eff  = (w_presc_even < PRESCALE_W'(MIN_PRESCALE)) ? PRESCALE_W'(MIN_PRESCALE)
                                                                   : w_presc_even;
  assign w_half    = r_prescale >> 1;
  assign w_decide  = (r_edge_cnt == w_half + PRESCALE_W'(1));
  assign w_bit_end = (r_edge_cnt == r_prescale - PRESCALE_W'(1));

  // Even parity: data plus parity bit XOR to 0; odd parity: XOR to 1.
  assign w_par_mismatch = ((^r_shift) ^ r_par_bit) != r_par_typ;

  // The last stop bit closes the frame at its decision point so a back-to-back
  // start edge can still be caught during the second half of that stop bit.
  assign w_final = w_decide && (((r_state == S_STOP1) && !r_stp2) || (r_state == S_STOP2));
  assign w_final_stp_err = r_stp1_err | !w_bit;
  assign w_final_par_err = r_par_en & w_par_mismatch;

`ifdef UART_RX_BREAK_DET_EN
  logic r_brk_det;
  logic w_brk_hit;
  // Break: all-zero data, zero parity (if present) and a low first stop bit.
  assign w_brk_hit  = (r_state == S_STOP1) && w_decide && (r_shift == '0) &&
                      !(r_par_en && r_par_bit) && !w_bit;
  assign w_final_ok = w_final && !w_brk_hit;
  assign brk_det    = r_brk_det;
`else
  assign w_final_ok = w_final;
  assign brk_det    = 1'b0;
`endif

  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .i_clk      (CLK),
    .i_rst_n    (RST),
    .i_rx       (RX_IN),
    .i_edge_cnt (r_edge_cnt),
    .i_half     (w_half),
    .o_rx_sync  (w_rx_sync),
    .o_bit      (w_bit)
  );

  // Frame FSM: bit timing, data shifting, and registered result pulses.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state      <= S_IDLE;
      r_edge_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_prescale   <= PRESCALE_W'(MIN_PRESCALE);
      r_par_en     <= 1'b0;
      r_par_typ    <= 1'b0;
      r_stp2       <= 1'b0;
      r_shift      <= '0;
      r_par_bit    <= 1'b0;
      r_stp1_err   <= 1'b0;
      r_p_data     <= '0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      r_brk_det    <= 1'b0;
`endif
    end else begin
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      r_brk_det    <= 1'b0;
`endif
      if (w_bit_end) r_edge_cnt <= '0;
      else           r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);

      case (r_state)
        S_IDLE: begin
          if (!w_rx_sync) begin
            r_state    <= S_START;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_stp1_err <= 1'b0;
            r_par_en   <= PAR_EN;
            r_par_typ  <= PAR_TYP;
            r_stp2     <= STP2;
            r_prescale <= w_presc_eff;
          end
        end
        S_START: begin
          if (w_decide && w_bit) r_state <= S_IDLE;
          else if (w_bit_end)    r_state <= S_DATA;
        end
        S_DATA: begin
          if (w_decide) r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
          if (w_bit_end) begin
            if (r_bit_cnt == BCW'(DATA_WIDTH - 1)) begin
              r_bit_cnt <= '0;
              r_state   <= r_par_en ? S_PARITY : S_STOP1;
            end else begin
              r_bit_cnt <= r_bit_cnt + BCW'(1);
            end
          end
        end
        S_PARITY: begin
          if (w_decide)  r_par_bit <= w_bit;
          if (w_bit_end) r_state   <= S_STOP1;
        end
        S_STOP1: begin
          if (w_decide && r_stp2)  r_stp1_err <= !w_bit;
          if (w_bit_end && r_stp2) r_state    <= S_STOP2;
`ifdef UART_RX_BREAK_DET_EN
          if (w_brk_hit) begin
            r_state   <= S_BREAK_WAIT;
            r_brk_det <= 1'b1;
          end
`endif
        end
        S_STOP2: ;
`ifdef UART_RX_BREAK_DET_EN
        S_BREAK_WAIT: begin
          if (w_rx_sync) r_state <= S_IDLE;
        end
`endif
        default: r_state <= S_IDLE;
      endcase

      if (w_final_ok) begin
        r_state <= S_IDLE;
        if (w_final_stp_err || w_final_par_err) begin
          r_stp_err <= w_final_stp_err;
          r_par_err <= w_final_par_err;
        end else begin
          r_data_valid <= 1'b1;
          r_p_data     <= r_shift;
        end
      end
    end
  end

  assign P_DATA     = r_p_data;
  assign data_valid = r_data_valid;
  assign par_err    = r_par_err;
  assign stp_err    = r_stp_err;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg with a scoreboard of expected result pulses.
// Break expectations follow `define UART_RX_BREAK_DET_EN.
module tb_uart_rx_cfg;
  import uart_rx_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       STP2 = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       brk_det;

  typedef struct packed {
    logic       dv;
    logic       pe;
    logic       se;
    logic       bd;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  int         n_assert = 0;
  int         n_fail = 0;
  logic [7:0] last_good = 8'h00;

  uart_rx_cfg #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STP2       (STP2),
    .Prescale   (Prescale),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .brk_det    (brk_det)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic exp_ok(input logic [7:0] d);
    exp_q.push_back('{dv: 1'b1, pe: 1'b0, se: 1'b0, bd: 1'b0, data: d});
    last_good = d;
  endtask

  task automatic exp_err(input logic pe, input logic se);
    exp_q.push_back('{dv: 1'b0, pe: pe, se: se, bd: 1'b0, data: last_good});
  endtask

  task automatic exp_brk();
    exp_q.push_back('{dv: 1'b0, pe: 1'b0, se: 1'b0, bd: 1'b1, data: last_good});
  endtask

  // One frame on RX_IN with explicit parity/stop levels; p is the bit period in cycles.
  task automatic send_frame(input logic [7:0] d, input int p, input logic par_en,
                            input logic par_bit, input logic stp2,
                            input logic stop1_v, input logic stop2_v);
    RX_IN = 1'b0;
    tick(p);
    for (int i = 0; i < 8; i++) begin
      RX_IN = d[i];
      tick(p);
    end
    if (par_en) begin
      RX_IN = par_bit;
      tick(p);
    end
    RX_IN = stop1_v;
    tick(p);
    if (stp2) begin
      RX_IN = stop2_v;
      tick(p);
    end
    RX_IN = 1'b1;
  endtask

  task automatic idle_bits(input int nbits, input int p);
    RX_IN = 1'b1;
    tick(nbits * p);
  endtask

  task automatic wait_drain(input string tag, input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) tick(1);
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: pops the scoreboard on every result pulse and guards P_DATA stability.
  initial begin
    exp_t       e;
    logic [7:0] prev_pdata = 8'h00;
    logic       prev_rst_hi = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST && prev_rst_hi)
        chk("pdata_only_on_valid", 32'((P_DATA === prev_pdata) || (data_valid === 1'b1)), 32'd1);
      if (data_valid || par_err || stp_err || brk_det) begin
        $display("t=%0t event dv=%0b pe=%0b se=%0b bd=%0b P_DATA=%02h",
                 $time, data_valid, par_err, stp_err, brk_det, P_DATA);
        chk("event_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("event_flags", 32'({data_valid, par_err, stp_err, brk_det}),
              32'({e.dv, e.pe, e.se, e.bd}));
          chk("event_pdata", 32'(P_DATA), 32'(e.data));
        end
      end
      prev_pdata  = P_DATA;
      prev_rst_hi = RST;
    end
  end

  initial begin
    // Reset state
    RST = 1'b0;
    tick(4);
    chk("rst_pdata", 32'(P_DATA), 32'h0);
    chk("rst_dv", 32'(data_valid), 32'h0);
    chk("rst_pe", 32'(par_err), 32'h0);
    chk("rst_se", 32'(stp_err), 32'h0);
    chk("rst_bd", 32'(brk_det), 32'h0);
    chk("rst_state", 32'(dut.r_state), 32'(S_IDLE));
    chk("rst_sync", 32'(dut.u_sampler.r_sync2), 32'h1);
    RST = 1'b1;
    idle_bits(2, 8);

    // 8N1, prescale 8, 0xA5
    exp_ok(8'hA5);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_drain("drain_a5", 200);
    idle_bits(2, 8);

    // Odd prescale 9 behaves as 8
    Prescale = 6'd9;
    exp_ok(8'hC3);
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_drain("drain_c3", 200);
    idle_bits(2, 8);

    // Even parity, 0x0F with parity bit 1 -> parity error, P_DATA unchanged
    Prescale = 6'd8;
    PAR_EN = 1'b1;
    PAR_TYP = 1'b0;
    exp_err(1'b1, 1'b0);
    send_frame(8'h0F, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_drain("drain_par_err", 200);
    idle_bits(2, 8);

    // Odd parity, good frame
    PAR_TYP = 1'b1;
    exp_ok(8'h07);
    send_frame(8'h07, 8, 1'b1, ~^8'h07, 1'b0, 1'b1, 1'b1);
    wait_drain("drain_odd_ok", 200);
    idle_bits(2, 8);

    // Parity and stop errors together
    PAR_TYP = 1'b0;
    exp_err(1'b1, 1'b1);
    send_frame(8'hF0, 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_drain("drain_par_stp", 200);
    idle_bits(3, 8);

    // 3-cycle start glitch at prescale 16, then 0x3C
    PAR_EN = 1'b0;
    Prescale = 6'd16;
    RX_IN = 1'b0;
    tick(3);
    RX_IN = 1'b1;
    tick(60);
    chk("glitch_idle", 32'(dut.r_state), 32'(S_IDLE));
    chk("glitch_no_event", 32'(exp_q.size()), 32'd0);
    exp_ok(8'h3C);
    send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_drain("drain_3c", 300);
    idle_bits(2, 16);

    // Two stop bits at prescale 32: first stop low, then second stop low
    STP2 = 1'b1;
    Prescale = 6'd32;
    exp_err(1'b0, 1'b1);
    send_frame(8'h34, 32, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_drain("drain_stop1_low", 500);
    idle_bits(2, 32);
    exp_err(1'b0, 1'b1);
    send_frame(8'h12, 32, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_drain("drain_stop2_low", 500);
    idle_bits(2, 32);

    // Back-to-back frames with zero idle
    exp_ok(8'h55);
    exp_ok(8'hAA);
    send_frame(8'h55, 32, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    send_frame(8'hAA, 32, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_drain("drain_b2b", 500);
    idle_bits(2, 32);

    // Prescale changes mid-frame: current frame keeps 8, next uses 16
    STP2 = 1'b0;
    Prescale = 6'd8;
    exp_ok(8'h96);
    fork
      send_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      begin
        tick(30);
        Prescale = 6'd16;
      end
    join
    wait_drain("drain_96", 200);
    idle_bits(2, 16);
    exp_ok(8'h69);
    send_frame(8'h69, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_drain("drain_69", 300);
    idle_bits(2, 16);

    // Line held low for 12 bit times at prescale 8
    Prescale = 6'd8;
`ifdef UART_RX_BREAK_DET_EN
    exp_brk();
`else
    exp_err(1'b0, 1'b1);
`endif
    RX_IN = 1'b0;
    tick(12 * 8);
    wait_drain("drain_break", 100);
    RX_IN = 1'b1;
    tick(8);
`ifdef UART_RX_BREAK_DET_EN
    chk("break_back_idle", 32'(dut.r_state), 32'(S_IDLE));
`endif
    // Reset while a frame may be in flight; nothing must be reported
    RST = 1'b0;
    tick(2);
    chk("midrst_pdata", 32'(P_DATA), 32'h0);
    last_good = 8'h00;
    RST = 1'b1;
    idle_bits(2, 8);

    // Reset in the middle of a deliberate frame
    RX_IN = 1'b0;
    tick(8);
    RX_IN = 1'b1;
    tick(8);
    RX_IN = 1'b0;
    tick(8);
    RST = 1'b0;
    tick(2);
    RST = 1'b1;
    idle_bits(20, 8);
    chk("midframe_rst_idle", 32'(dut.r_state), 32'(S_IDLE));
    chk("midframe_rst_pdata", 32'(P_DATA), 32'h0);
    exp_ok(8'h81);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_drain("drain_81", 200);
    idle_bits(2, 8);

    chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
